// File: rtl/sdram_cmd_arb_if.sv
// Bus bundle between the SDRAM command arbiter and its sources / the chip pins.
// master: the side that owns the init sequencer, refresh generator and channels.
// slave:  the arbiter itself.
interface sdram_cmd_arb_if #(
  parameter int CH_NUM = 2,
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
);
  logic                     init_end;
  logic [3:0]               init_cmd;
  logic [BA_W-1:0]          init_ba;
  logic [ADDR_W-1:0]        init_addr;

  logic                     aref_req;
  logic                     aref_end;
  logic [3:0]               aref_cmd;
  logic [BA_W-1:0]          aref_ba;
  logic [ADDR_W-1:0]        aref_addr;
  logic                     aref_en;

  logic [CH_NUM-1:0]        ch_req;
  logic [CH_NUM-1:0]        ch_end;
  logic [CH_NUM*4-1:0]      ch_cmd;
  logic [CH_NUM*BA_W-1:0]   ch_ba;
  logic [CH_NUM*ADDR_W-1:0] ch_addr;
  logic [CH_NUM-1:0]        ch_dq_oe;
  logic [CH_NUM*DQ_W-1:0]   ch_dq;
  logic [CH_NUM-1:0]        ch_gnt;

  logic [3:0]               sdram_cmd;
  logic [BA_W-1:0]          sdram_ba;
  logic [ADDR_W-1:0]        sdram_addr;
  logic                     sdram_dq_oe;
  logic [DQ_W-1:0]          sdram_dq_out;

  modport master (
    output init_end, init_cmd, init_ba, init_addr,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output ch_req, ch_end, ch_cmd, ch_ba, ch_addr, ch_dq_oe, ch_dq,
    input  aref_en, ch_gnt,
    input  sdram_cmd, sdram_ba, sdram_addr, sdram_dq_oe, sdram_dq_out
  );

  modport slave (
    input  init_end, init_cmd, init_ba, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  ch_req, ch_end, ch_cmd, ch_ba, ch_addr, ch_dq_oe, ch_dq,
    output aref_en, ch_gnt,
    output sdram_cmd, sdram_ba, sdram_addr, sdram_dq_oe, sdram_dq_out
  );
endinterface

// File: rtl/sdram_cmd_arb.sv
// SDRAM command arbiter: init sequencer, auto-refresh and CH_NUM burst channels
// share one cmd/ba/addr/DQ port. Refresh wins every arbitration but never
// interrupts a burst; channels are served round-robin.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | init sequencer owns the bus, waiting for init_end
// ST_ARB  | idle NOP cycle, arbitration happens here
// ST_AREF | refresh generator owns the bus until aref_end
// ST_CH   | granted channel owns the bus until its ch_end
module sdram_cmd_arb #(
  parameter int CH_NUM = 2,
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
) (
  input logic             sys_clk,
  input logic             sys_rst,
  sdram_cmd_arb_if.slave  bus
);

  localparam int         IDX_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [1:0] {ST_INIT, ST_ARB, ST_AREF, ST_CH} state_t;

  state_t            state;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  rr_next;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [CH_NUM-1:0] pick_oh;
  logic [CH_NUM-1:0] gnt_vec;
  logic              aref_grant;

  // Round-robin search: first requesting channel at or after rr_ptr.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    int cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % CH_NUM;
      if (bus.ch_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  // One-hot form of the picked channel, loaded into the grant register.
  always_comb begin
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  assign rr_next = (int'(gnt_idx) == CH_NUM - 1) ? '0 : gnt_idx + 1'b1;

  // Bus ownership FSM; grants are registered so request inputs never reach
  // the outputs combinationally.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_INIT;
      gnt_vec    <= '0;
      gnt_idx    <= '0;
      aref_grant <= 1'b0;
      rr_ptr     <= '0;
    end else if (state != ST_INIT && !bus.init_end) begin
      state      <= ST_INIT;
      gnt_vec    <= '0;
      aref_grant <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (bus.init_end) state <= ST_ARB;
        end
        ST_ARB: begin
          if (bus.aref_req) begin
            state      <= ST_AREF;
            aref_grant <= 1'b1;
          end else if (pick_vld) begin
            state   <= ST_CH;
            gnt_vec <= pick_oh;
            gnt_idx <= pick_idx;
          end
        end
        ST_AREF: begin
          if (bus.aref_end) begin
            state      <= ST_ARB;
            aref_grant <= 1'b0;
          end
        end
        ST_CH: begin
          // Only the owner's end pulse releases the bus.
          if (bus.ch_end[gnt_idx]) begin
            state   <= ST_ARB;
            gnt_vec <= '0;
            rr_ptr  <= rr_next;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.ch_gnt  = gnt_vec;
  assign bus.aref_en = aref_grant;

  // Pin mux driven from the registered owner; command data passes straight through.
  always_comb begin
    bus.sdram_cmd    = CMD_NOP;
    bus.sdram_ba     = '1;
    bus.sdram_addr   = '0;
    bus.sdram_dq_oe  = 1'b0;
    bus.sdram_dq_out = '0;
    case (state)
      ST_INIT: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_ba   = bus.init_ba;
        bus.sdram_addr = bus.init_addr;
      end
      ST_AREF: begin
        bus.sdram_cmd  = bus.aref_cmd;
        bus.sdram_ba   = bus.aref_ba;
        bus.sdram_addr = bus.aref_addr;
      end
      ST_CH: begin
        bus.sdram_cmd   = bus.ch_cmd[int'(gnt_idx)*4 +: 4];
        bus.sdram_ba    = bus.ch_ba[int'(gnt_idx)*BA_W +: BA_W];
        bus.sdram_addr  = bus.ch_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        bus.sdram_dq_oe = bus.ch_dq_oe[gnt_idx];
        if (bus.ch_dq_oe[gnt_idx]) bus.sdram_dq_out = bus.ch_dq[int'(gnt_idx)*DQ_W +: DQ_W];
      end
      default: ;
    endcase
  end

endmodule
